// File: rtl/framing_pkg.sv
// Shared VLQ constants and parser state encoding for the framing receive path.
package framing_pkg;

    localparam int         VLQ_CONT_BIT  = 7;
    localparam int         VLQ_MAX_BYTES = 5;
    localparam logic [1:0] VLQ_NEG_MASK  = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ID    = 3'd1,
        ST_ARG   = 3'd2,
        ST_EMIT  = 3'd3,
        ST_ERROR = 3'd4
    } parser_state_e;

endpackage

// File: rtl/vlq_accum.sv
// VLQ value accumulator: folds one byte per strobe into a 32-bit value and
// flags completion (clear continuation bit) or an overlong encoding.
module vlq_accum
    import framing_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  byte_in,
    input  logic        strobe,
    input  logic        start,
    output logic [31:0] value,
    output logic        done,
    output logic        overlong
);

    logic [31:0] acc_q, acc_d;
    logic [2:0]  cnt_q, cnt_d;

    // value reflects the current byte so the FSM can act in the consuming cycle
    always_comb begin
        value = {acc_q[24:0], byte_in[6:0]};
        if (cnt_q == 3'd0) begin
            value = {25'd0, byte_in[6:0]};
            if (byte_in[6:5] == VLQ_NEG_MASK) begin
                value = value | 32'hFFFF_FFE0;
            end
        end

        overlong = strobe && (cnt_q == 3'(VLQ_MAX_BYTES));
        done     = strobe && !byte_in[VLQ_CONT_BIT] && !overlong;

        acc_d = acc_q;
        cnt_d = cnt_q;
        if (start || done) begin
            acc_d = '0;
            cnt_d = '0;
        end else if (strobe && !overlong) begin
            acc_d = value;
            cnt_d = cnt_q + 3'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
            cnt_q <= '0;
        end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/msg_parser.sv
// Decodes VLQ command id plus table-sized argument list into one command word.
// Optional MSG_PARSER_CNT_EN adds a free-running handshake counter output.
module msg_parser
    import framing_pkg::*;
#(
    parameter int                    NUM_CMDS    = 16,
    parameter int                    MAX_ARGS    = 4,
    parameter logic [NUM_CMDS*4-1:0] NARGS_TABLE = '0,
    parameter int                    CMD_BITS    = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [7:0]            msg_data,
    input  logic                  msg_ready,
    output logic                  msg_rd_en,
    output logic                  cmd_valid,
    input  logic                  cmd_ready,
    output logic [CMD_BITS-1:0]   cmd_id,
    output logic [3:0]            cmd_nargs,
    output logic [MAX_ARGS*32-1:0] cmd_args,
    output logic                  error,
`ifdef MSG_PARSER_CNT_EN
    output logic [15:0]           cmd_count,
`endif
    input  logic                  clr
);

    parser_state_e          state_q, state_d;
    logic [CMD_BITS-1:0]    id_q, id_d;
    logic [3:0]             nargs_q, nargs_d;
    logic [3:0]             idx_q, idx_d;
    logic [MAX_ARGS*32-1:0] args_q, args_d;

    logic        reading;
    logic        acc_strobe;
    logic        acc_start;
    logic [31:0] acc_value;
    logic        acc_done;
    logic        acc_overlong;
    logic        id_known;
    logic [3:0]  tbl_nargs;

    assign reading    = (state_q == ST_IDLE) || (state_q == ST_ID) || (state_q == ST_ARG);
    assign msg_rd_en  = rst_n && msg_ready && reading;
    assign acc_strobe = msg_rd_en && !clr;
    assign acc_start  = clr || !reading;

    vlq_accum u_vlq (
        .clk      (clk),
        .rst_n    (rst_n),
        .byte_in  (msg_data),
        .strobe   (acc_strobe),
        .start    (acc_start),
        .value    (acc_value),
        .done     (acc_done),
        .overlong (acc_overlong)
    );

    always_comb begin
        id_known  = 1'b0;
        tbl_nargs = '0;
        for (int i = 0; i < NUM_CMDS; i++) begin
            if (acc_value == 32'(i)) begin
                id_known  = 1'b1;
                tbl_nargs = NARGS_TABLE[4*i +: 4];
            end
        end
    end

    // clr overrides everything, including a handshake or a byte in flight
    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        nargs_d = nargs_q;
        idx_d   = idx_q;
        args_d  = args_q;
        if (clr) begin
            state_d = ST_IDLE;
            id_d    = '0;
            nargs_d = '0;
            idx_d   = '0;
            args_d  = '0;
        end else begin
            case (state_q)
                ST_IDLE, ST_ID: begin
                    if (acc_overlong) begin
                        state_d = ST_ERROR;
                    end else if (acc_done) begin
                        if (!id_known || (tbl_nargs > 4'(MAX_ARGS))) begin
                            state_d = ST_ERROR;
                        end else begin
                            id_d    = acc_value[CMD_BITS-1:0];
                            nargs_d = tbl_nargs;
                            idx_d   = '0;
                            state_d = (tbl_nargs == 4'd0) ? ST_EMIT : ST_ARG;
                        end
                    end else if (acc_strobe) begin
                        state_d = ST_ID;
                    end
                end
                ST_ARG: begin
                    if (acc_overlong) begin
                        state_d = ST_ERROR;
                    end else if (acc_done) begin
                        for (int k = 0; k < MAX_ARGS; k++) begin
                            if (idx_q == 4'(k)) begin
                                args_d[32*k +: 32] = acc_value;
                            end
                        end
                        idx_d = idx_q + 4'd1;
                        if ((idx_q + 4'd1) == nargs_q) begin
                            state_d = ST_EMIT;
                        end
                    end
                end
                ST_EMIT: begin
                    if (cmd_ready) begin
                        state_d = ST_IDLE;
                        idx_d   = '0;
                        args_d  = '0;
                    end
                end
                ST_ERROR: begin
                    state_d = ST_ERROR;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            id_q    <= '0;
            nargs_q <= '0;
            idx_q   <= '0;
            args_q  <= '0;
        end else begin
            state_q <= state_d;
            id_q    <= id_d;
            nargs_q <= nargs_d;
            idx_q   <= idx_d;
            args_q  <= args_d;
        end
    end

    assign cmd_valid = (state_q == ST_EMIT);
    assign error     = (state_q == ST_ERROR);
    assign cmd_id    = id_q;
    assign cmd_nargs = nargs_q;
    assign cmd_args  = args_q;

`ifdef MSG_PARSER_CNT_EN
    logic [15:0] count_q, count_d;

    // survives clr; only reset clears it
    always_comb begin
        count_d = count_q;
        if ((state_q == ST_EMIT) && cmd_ready && !clr) begin
            count_d = count_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign cmd_count = count_q;
`endif

endmodule

// File: tb/tb_msg_parser.sv
// Self-checking bench for msg_parser: vector table, hand-written corner cases
// and randomized commands checked against a VLQ-encoding reference model.
module tb_msg_parser;

    localparam logic [63:0] NARGS = 64'h1F02_1430_2194_2301;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [7:0]     msg_data;
    logic           msg_ready;
    logic           msg_rd_en;
    logic           cmd_valid;
    logic           cmd_ready;
    logic [7:0]     cmd_id;
    logic [3:0]     cmd_nargs;
    logic [127:0]   cmd_args;
    logic           error;
    logic           clr;
`ifdef MSG_PARSER_CNT_EN
    logic [15:0]    cmd_count;
`endif

    int checks = 0;
    int errors = 0;
    int hs_count = 0;
    int nargs_tab [16] = '{1, 0, 3, 2, 4, 9, 1, 2, 0, 3, 4, 1, 2, 0, 15, 1};
    logic [7:0] bq [$];

    typedef struct {
        int                 nbytes;
        logic [0:9][7:0]    bytes;
        logic               exp_err;
        logic [7:0]         exp_id;
        logic [3:0]         exp_nargs;
        logic [0:3][31:0]   exp_args;
    } vec_t;

    vec_t vecs [9];

    msg_parser #(
        .NUM_CMDS    (16),
        .MAX_ARGS    (4),
        .NARGS_TABLE (NARGS),
        .CMD_BITS    (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .msg_data  (msg_data),
        .msg_ready (msg_ready),
        .msg_rd_en (msg_rd_en),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_id    (cmd_id),
        .cmd_nargs (cmd_nargs),
        .cmd_args  (cmd_args),
        .error     (error),
`ifdef MSG_PARSER_CNT_EN
        .cmd_count (cmd_count),
`endif
        .clr       (clr)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Offers one byte after an optional gap and waits (bounded) for it to be consumed.
    task automatic applyStimulus(input logic [7:0] b, input int gap);
        int waited;
        msg_ready = 1'b0;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
        msg_data  = b;
        msg_ready = 1'b1;
        waited    = 0;
        @(negedge clk);
        while (!msg_rd_en && waited < 40) begin
            @(negedge clk);
            waited++;
        end
        if (!msg_rd_en) begin
            checks++;
            errors++;
            $display("[TB] FAIL rd_timeout: byte %h never consumed", b);
        end
        @(posedge clk);
        #1;
        msg_ready = 1'b0;
    endtask

    task automatic check_cmd(input string tag, input logic [7:0] id, input logic [3:0] n,
                             input logic [0:3][31:0] args);
        checkOutput({tag, "_valid"}, 32'(cmd_valid), 32'd1);
        checkOutput({tag, "_id"}, 32'(cmd_id), 32'(id));
        checkOutput({tag, "_nargs"}, 32'(cmd_nargs), 32'(n));
        for (int k = 0; k < 4; k++) begin
            checkOutput($sformatf("%s_arg%0d", tag, k), cmd_args[32*k +: 32], args[k]);
        end
    endtask

    task automatic do_accept(input string tag);
        cmd_ready = 1'b1;
        @(posedge clk);
        #1;
        cmd_ready = 1'b0;
        msg_ready = 1'b0;
        hs_count++;
        checkOutput({tag, "_acc_valid"}, 32'(cmd_valid), 32'd0);
        checkOutput({tag, "_acc_args_clr"}, 32'(|cmd_args), 32'd0);
    endtask

    task automatic pulse_clr();
        clr = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0;
    endtask

    task automatic check_reset(input string tag);
        checkOutput({tag, "_rd_en"}, 32'(msg_rd_en), 32'd0);
        checkOutput({tag, "_valid"}, 32'(cmd_valid), 32'd0);
        checkOutput({tag, "_id"}, 32'(cmd_id), 32'd0);
        checkOutput({tag, "_nargs"}, 32'(cmd_nargs), 32'd0);
        checkOutput({tag, "_args"}, 32'(|cmd_args), 32'd0);
        checkOutput({tag, "_error"}, 32'(error), 32'd0);
`ifdef MSG_PARSER_CNT_EN
        checkOutput({tag, "_count"}, 32'(cmd_count), 32'd0);
`endif
    endtask

    // Reference encoder: shortest VLQ whose decode reproduces v in 32 bits.
    task automatic push_value(input logic [31:0] v);
        int n;
        int t;
        for (n = 1; n < 5; n++) begin
            t = int'($signed(v)) >>> (7 * (n - 1));
            if (t >= -32 && t <= 95) break;
        end
        if (n == 5) begin
            bq.push_back({1'b1, 3'b000, v[31:28]});
        end else begin
            t = int'($signed(v)) >>> (7 * (n - 1));
            bq.push_back({(n > 1), t[6:0]});
        end
        for (int j = n - 2; j >= 0; j--) begin
            bq.push_back({(j > 0), v[7*j +: 7]});
        end
    endtask

    function automatic logic [31:0] rand_value();
        case ($urandom_range(0, 3))
            0:       return 32'($urandom_range(0, 95));
            1:       return -32'($urandom_range(1, 32));
            2:       return 32'($urandom_range(0, 20000));
            default: return $urandom();
        endcase
    endfunction

    initial begin
        int id;
        int n;
        logic [0:3][31:0] exp_args;

        vecs[0] = '{4, {8'h03, 8'h05, 8'h81, 8'h00, 48'h0}, 1'b0, 8'd3, 4'd2,
                    {32'd5, 32'd128, 64'd0}};
        vecs[1] = '{3, {8'h03, 8'h7F, 8'h60, 56'h0}, 1'b0, 8'd3, 4'd2,
                    {32'hFFFF_FFFF, 32'hFFFF_FFE0, 64'd0}};
        vecs[2] = '{7, {8'h04, 8'h00, 8'h3F, 8'h5F, 8'h82, 8'hFF, 8'h7F, 24'h0}, 1'b0, 8'd4, 4'd4,
                    {32'd0, 32'd63, 32'd95, 32'h0000_BFFF}};
        vecs[3] = '{6, {8'h00, 8'hC1, 8'h80, 8'h80, 8'h80, 8'h05, 32'h0}, 1'b0, 8'd0, 4'd1,
                    {32'h1000_0005, 96'd0}};
        vecs[4] = '{5, {8'h80, 8'h02, 8'h01, 8'h02, 8'h03, 40'h0}, 1'b0, 8'd2, 4'd3,
                    {32'd1, 32'd2, 32'd3, 32'd0}};
        vecs[5] = '{1, {8'h05, 72'h0}, 1'b1, 8'd0, 4'd0, 128'd0};
        vecs[6] = '{1, {8'h0E, 72'h0}, 1'b1, 8'd0, 4'd0, 128'd0};
        vecs[7] = '{1, {8'h0D, 72'h0}, 1'b0, 8'd13, 4'd0, 128'd0};
        vecs[8] = '{3, {8'h06, 8'hE0, 8'h00, 56'h0}, 1'b0, 8'd6, 4'd1,
                    {32'hFFFF_F000, 96'd0}};

        rst_n     = 1'b0;
        msg_data  = 8'h00;
        msg_ready = 1'b1;
        cmd_ready = 1'b0;
        clr       = 1'b0;
        #12;
        check_reset("reset");
        msg_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int v = 0; v < 9; v++) begin
            for (int b = 0; b < vecs[v].nbytes; b++) begin
                applyStimulus(vecs[v].bytes[b], 0);
            end
            if (vecs[v].exp_err) begin
                msg_data  = 8'h01;
                msg_ready = 1'b1;
                @(negedge clk);
                checkOutput($sformatf("vec%0d_error", v), 32'(error), 32'd1);
                checkOutput($sformatf("vec%0d_rd_en", v), 32'(msg_rd_en), 32'd0);
                pulse_clr();
                msg_ready = 1'b0;
                checkOutput($sformatf("vec%0d_clr", v), 32'(error), 32'd0);
            end else begin
                check_cmd($sformatf("vec%0d", v), vecs[v].exp_id, vecs[v].exp_nargs, vecs[v].exp_args);
                do_accept($sformatf("vec%0d", v));
            end
        end

        // zero-arg command held in EMIT while the dispatcher stalls
        applyStimulus(8'h01, 0);
        check_cmd("stall", 8'd1, 4'd0, 128'd0);
        msg_data  = 8'h03;
        msg_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            checkOutput($sformatf("stall%0d_valid", c), 32'(cmd_valid), 32'd1);
            checkOutput($sformatf("stall%0d_id", c), 32'(cmd_id), 32'd1);
            checkOutput($sformatf("stall%0d_rd_en", c), 32'(msg_rd_en), 32'd0);
        end
        do_accept("stall");
        applyStimulus(8'h03, 0);
        applyStimulus(8'h01, 0);
        applyStimulus(8'h02, 0);
        check_cmd("after_stall", 8'd3, 4'd2, {32'd1, 32'd2, 64'd0});
        do_accept("after_stall");

        // id beyond the command range
        applyStimulus(8'h14, 0);
        msg_data  = 8'h01;
        msg_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checkOutput("unk_error", 32'(error), 32'd1);
            checkOutput("unk_rd_en", 32'(msg_rd_en), 32'd0);
        end
        pulse_clr();
        checkOutput("unk_clr", 32'(error), 32'd0);
        applyStimulus(8'h01, 0);
        check_cmd("unk_fresh", 8'd1, 4'd0, 128'd0);
        do_accept("unk_fresh");

        // six bytes all carrying continuation
        for (int b = 0; b < 5; b++) begin
            applyStimulus(8'h80, 0);
            checkOutput($sformatf("ovl_pre%0d", b), 32'(error), 32'd0);
        end
        applyStimulus(8'h80, 0);
        checkOutput("ovl_error", 32'(error), 32'd1);
        pulse_clr();
        checkOutput("ovl_clr", 32'(error), 32'd0);

        // clr and cmd_ready together: clr wins, no handshake counted
        applyStimulus(8'h08, 0);
        check_cmd("clr_ready", 8'd8, 4'd0, 128'd0);
        cmd_ready = 1'b1;
        clr       = 1'b1;
        @(posedge clk);
        #1;
        cmd_ready = 1'b0;
        clr       = 1'b0;
        checkOutput("clr_ready_valid", 32'(cmd_valid), 32'd0);
        checkOutput("clr_ready_error", 32'(error), 32'd0);
`ifdef MSG_PARSER_CNT_EN
        checkOutput("clr_ready_count", 32'(cmd_count), 32'(hs_count));
`endif

        // dribbled bytes, then reset in the middle of an argument
        applyStimulus(8'h04, 2);
        applyStimulus(8'h05, 1);
        applyStimulus(8'h85, 3);
        msg_data  = 8'h11;
        msg_ready = 1'b1;
        #3;
        rst_n = 1'b0;
        #1;
        check_reset("midrst");
        hs_count = 0;
        @(negedge clk);
        rst_n     = 1'b1;
        msg_ready = 1'b0;
        @(posedge clk);
        #1;
        applyStimulus(8'h80, 1);
        applyStimulus(8'h02, 2);
        applyStimulus(8'h01, 0);
        applyStimulus(8'h02, 3);
        applyStimulus(8'h03, 1);
        check_cmd("postrst", 8'd2, 4'd3, {32'd1, 32'd2, 32'd3, 32'd0});
        do_accept("postrst");

        // randomized commands against the encoder model
        for (int c = 0; c < 40; c++) begin
            do begin
                id = $urandom_range(0, 15);
            end while (nargs_tab[id] > 4);
            n = nargs_tab[id];
            bq.delete();
            push_value(32'(id));
            exp_args = '0;
            for (int k = 0; k < n; k++) begin
                exp_args[k] = rand_value();
                push_value(exp_args[k]);
            end
            foreach (bq[i]) begin
                applyStimulus(bq[i], $urandom_range(0, 2));
            end
            check_cmd($sformatf("rnd%0d", c), 8'(id), 4'(n), exp_args);
            repeat ($urandom_range(0, 3)) begin
                @(posedge clk);
                #1;
                checkOutput($sformatf("rnd%0d_hold", c), 32'(cmd_valid), 32'd1);
            end
            do_accept($sformatf("rnd%0d", c));
        end

`ifdef MSG_PARSER_CNT_EN
        checkOutput("final_count", 32'(cmd_count), 32'(hs_count));
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
